sketch_hot_reporter: RTL and testbench

Consumer of the per-row counts returned by the count-min sketch bank. It tracks each request's address alongside the sketch pipeline and reduces the NUM_HASH row counts to their minimum through a registered tree. When the minimum reaches a programmable threshold, it queues a hot-address report. Reports drain to the host-side report logic over a valid/ready stream; reports that arrive while the queue is full are counted and dropped.

---
 rtl/sketch_hot_reporter.sv | 160 ++++++++++++++++
 tb/tb_sketch_hot_reporter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sketch_hot_reporter.sv
// Hot-address reporter: aligns request addresses with count-min sketch row counts,
// reduces them to a minimum, and queues a report when the minimum hits the threshold.
module sketch_hot_reporter #(
   parameter int unsigned NUM_HASH   = 4,
   parameter int unsigned ADDR_SIZE  = 22,
   parameter int unsigned CNT_SIZE   = 32,
   parameter int unsigned SKETCH_LAT = 3,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              query_rst_n,
   input  logic                              in_valid,
   input  logic [ADDR_SIZE-1:0]              in_addr,
   input  logic [NUM_HASH-1:0][CNT_SIZE-1:0] cnt_array,
   input  logic [CNT_SIZE-1:0]               threshold,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [ADDR_SIZE-1:0]              out_addr,
   output logic [CNT_SIZE-1:0]               out_cnt,
   output logic [15:0]                       drop_cnt,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

   localparam int unsigned LOG   = $clog2(NUM_HASH);
   localparam int unsigned PW    = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W = PW + 1;
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

   logic                 qr_d1_d, qr_d1_q;
   logic                 clear_c;
   logic                 dl_v_d [SKETCH_LAT];
   logic                 dl_v_q [SKETCH_LAT];
   logic [ADDR_SIZE-1:0] dl_a_d [SKETCH_LAT];
   logic [ADDR_SIZE-1:0] dl_a_q [SKETCH_LAT];
   logic                 st_v_d [LOG];
   logic                 st_v_q [LOG];
   logic [ADDR_SIZE-1:0] st_a_d [LOG];
   logic [ADDR_SIZE-1:0] st_a_q [LOG];
   logic [CNT_SIZE-1:0]  node_c [2*NUM_HASH-2];
   logic [CNT_SIZE-1:0]  min_d  [NUM_HASH-1];
   logic [CNT_SIZE-1:0]  min_q  [NUM_HASH-1];
   logic                 hit_d, hit_q;
   logic [ADDR_SIZE-1:0] hit_addr_d, hit_addr_q;
   logic [CNT_SIZE-1:0]  hit_cnt_d, hit_cnt_q;
   logic [PTR_W-1:0]     wr_ptr_d, wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_d, rd_ptr_q;
   logic [15:0]          drop_cnt_d, drop_cnt_q;
   logic [ADDR_SIZE-1:0] mem_addr_q [FIFO_DEPTH];
   logic [CNT_SIZE-1:0]  mem_cnt_q  [FIFO_DEPTH];
   logic                 empty_c, full_c, push_c, pop_c;

   // Min tree stored leaves-first: node_c[0..N-1] are the sketch rows, the rest are registers.
   // Node ordering is the reverse of a breadth-first heap, so each level is contiguous.
   for (genvar i = 0; i < NUM_HASH; i++) begin : g_leaf
      assign node_c[i] = cnt_array[i];
   end
   for (genvar k = 0; k < NUM_HASH-2; k++) begin : g_inner
      assign node_c[NUM_HASH+k] = min_q[k];
   end
   for (genvar k = 0; k < NUM_HASH-1; k++) begin : g_min
      localparam int unsigned R  = NUM_HASH - 2 - k;
      localparam int unsigned C0 = 2*NUM_HASH - 3 - 2*R;
      localparam int unsigned C1 = 2*NUM_HASH - 4 - 2*R;
      assign min_d[k] = (node_c[C0] < node_c[C1]) ? node_c[C0] : node_c[C1];
   end

   always_comb begin
      qr_d1_d = query_rst_n;
      clear_c = !rst_n || !qr_d1_q;

      dl_v_d[0] = in_valid;
      dl_a_d[0] = in_addr;
      for (int unsigned i = 1; i < SKETCH_LAT; i++) begin
         dl_v_d[i] = dl_v_q[i-1];
         dl_a_d[i] = dl_a_q[i-1];
      end

      st_v_d[0] = dl_v_q[SKETCH_LAT-1];
      st_a_d[0] = dl_a_q[SKETCH_LAT-1];
      for (int unsigned s = 1; s < LOG; s++) begin
         st_v_d[s] = st_v_q[s-1];
         st_a_d[s] = st_a_q[s-1];
      end

      // Counts step by one, so equality fires once per address per epoch.
      hit_d      = st_v_q[LOG-1] && (threshold != '0) && (min_q[NUM_HASH-2] == threshold);
      hit_addr_d = st_a_q[LOG-1];
      hit_cnt_d  = min_q[NUM_HASH-2];

      empty_c  = (wr_ptr_q == rd_ptr_q);
      full_c   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      pop_c    = !empty_c && out_ready;
      push_c   = hit_q && (!full_c || pop_c);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);

      drop_cnt_d = drop_cnt_q;
      if (hit_q && !push_c && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end

      out_valid  = !empty_c;
      out_addr   = out_valid ? mem_addr_q[rd_ptr_q[PW-1:0]] : '0;
      out_cnt    = out_valid ? mem_cnt_q[rd_ptr_q[PW-1:0]]  : '0;
      drop_cnt   = drop_cnt_q;
      fifo_level = LVL_W'(wr_ptr_q - rd_ptr_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         qr_d1_q <= 1'b1;
      end else begin
         qr_d1_q <= qr_d1_d;
      end
   end

   // Pipeline and queue control; an epoch clear wipes everything in flight.
   always_ff @(posedge clk) begin
      if (clear_c) begin
         for (int unsigned i = 0; i < SKETCH_LAT; i++) begin
            dl_v_q[i] <= 1'b0;
            dl_a_q[i] <= '0;
         end
         for (int unsigned s = 0; s < LOG; s++) begin
            st_v_q[s] <= 1'b0;
            st_a_q[s] <= '0;
         end
         for (int unsigned k = 0; k < NUM_HASH-1; k++) begin
            min_q[k] <= '0;
         end
         hit_q      <= 1'b0;
         hit_addr_q <= '0;
         hit_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         dl_v_q     <= dl_v_d;
         dl_a_q     <= dl_a_d;
         st_v_q     <= st_v_d;
         st_a_q     <= st_a_d;
         min_q      <= min_d;
         hit_q      <= hit_d;
         hit_addr_q <= hit_addr_d;
         hit_cnt_q  <= hit_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_addr_q[wr_ptr_q[PW-1:0]] <= hit_addr_q;
         mem_cnt_q[wr_ptr_q[PW-1:0]]  <= hit_cnt_q;
      end
   end

endmodule

// File: tb/tb_sketch_hot_reporter.sv
// Bench for sketch_hot_reporter: directed scenarios plus random traffic,
// checked every cycle against a cycle-indexed queue model of the reporter.
module tb_sketch_hot_reporter;

   localparam int NH = 4;
   localparam int AW = 22;
   localparam int CW = 32;
   localparam int FD = 8;
   localparam int LW = 4;
   localparam int NC = 1024;

   typedef bit [NH-1:0][CW-1:0] rows_t;
   typedef struct packed {
      logic [AW-1:0] a;
      logic [CW-1:0] c;
   } rep_t;

   logic                     clk = 1'b0;
   logic                     rst_n, query_rst_n, in_valid, out_valid, out_ready;
   logic [AW-1:0]            in_addr, out_addr;
   logic [NH-1:0][CW-1:0]    cnt_array;
   logic [CW-1:0]            threshold, out_cnt;
   logic [15:0]              drop_cnt;
   logic [LW-1:0]            fifo_level;

   always #5 clk = ~clk;

   sketch_hot_reporter #(
      .NUM_HASH(NH), .ADDR_SIZE(AW), .CNT_SIZE(CW), .SKETCH_LAT(3), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .query_rst_n(query_rst_n),
      .in_valid(in_valid), .in_addr(in_addr), .cnt_array(cnt_array),
      .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_cnt(out_cnt), .drop_cnt(drop_cnt),
      .fifo_level(fifo_level)
   );

   int          n_cmp = 0;
   int          n_mis = 0;
   int          e = 0;
   rows_t       rows_sched [NC];
   bit          pend_v [NC];
   bit [AW-1:0] pend_a [NC];
   bit [CW-1:0] pend_c [NC];
   rep_t        mq [$];
   int          m_drop = 0;
   bit          m_qr = 1'b1;

   function automatic rows_t mk(input int unsigned a, input int unsigned b,
                                input int unsigned c, input int unsigned d);
      rows_t r;
      r[0] = CW'(a); r[1] = CW'(b); r[2] = CW'(c); r[3] = CW'(d);
      return r;
   endfunction

   function automatic bit [CW-1:0] row_min(input rows_t r);
      bit [CW-1:0] m = r[0];
      for (int j = 1; j < NH; j++) if (r[j] < m) m = r[j];
      return m;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, e);
      end
   endtask

   // One clock cycle: drive inputs, advance the model across the edge, compare after it.
   task automatic tick(input bit v, input logic [AW-1:0] a, input rows_t r);
      bit [CW-1:0] mn;
      rep_t        h;
      bit          exp_v;
      if (e + 8 >= NC) begin
         $display("FAIL tick_budget: cycle %0d exceeds table size %0d", e, NC);
         $fatal(1, "cycle budget exhausted");
      end
      in_valid  = v;
      in_addr   = a;
      cnt_array = rows_sched[e];
      if (v) begin
         rows_sched[e+3] = r;
         mn = row_min(r);
         if (threshold != 0 && mn == threshold) begin
            pend_v[e+6] = 1'b1;
            pend_a[e+6] = a;
            pend_c[e+6] = mn;
         end
      end
      if (!rst_n || !m_qr) begin
         for (int i = e; i < NC; i++) pend_v[i] = 1'b0;
         mq.delete();
         m_drop = 0;
      end else begin
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (pend_v[e]) begin
            if (mq.size() < FD) begin
               h.a = pend_a[e];
               h.c = pend_c[e];
               mq.push_back(h);
            end else if (m_drop < 65535) begin
               m_drop++;
            end
         end
      end
      m_qr = rst_n ? query_rst_n : 1'b1;
      @(posedge clk);
      #1;
      e++;
      exp_v = (mq.size() > 0);
      chk("out_valid",  64'(out_valid),  64'(exp_v));
      chk("out_addr",   64'(out_addr),   exp_v ? 64'(mq[0].a) : 64'd0);
      chk("out_cnt",    64'(out_cnt),    exp_v ? 64'(mq[0].c) : 64'd0);
      chk("drop_cnt",   64'(drop_cnt),   64'(m_drop));
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, '0);
   endtask

   initial begin
      rst_n = 1'b0; query_rst_n = 1'b1; in_valid = 1'b0; in_addr = '0;
      cnt_array = '0; threshold = 32'd3; out_ready = 1'b1;
      idle(3);
      chk("reset_out_valid",  64'(out_valid),  64'd0);
      chk("reset_fifo_level", 64'(fifo_level), 64'd0);
      rst_n = 1'b1;
      idle(3);

      // Rising minimums 1,2,3: only the third reports, 7 cycles after its request.
      tick(1'b1, 22'h1234, mk(1, 2, 3, 4));
      tick(1'b1, 22'h1234, mk(2, 3, 4, 5));
      tick(1'b1, 22'h1234, mk(3, 4, 5, 6));
      idle(5);
      chk("lat6_out_valid", 64'(out_valid), 64'd0);
      idle(1);
      chk("lat7_out_valid", 64'(out_valid), 64'd1);
      chk("lat7_out_addr",  64'(out_addr),  64'h1234);
      chk("lat7_out_cnt",   64'(out_cnt),   64'd3);
      idle(3);

      // Minimum in an inner row reports; minimum 4 does not.
      tick(1'b1, 22'h02A5, mk(5, 3, 9, 4));
      tick(1'b1, 22'h03B6, mk(5, 4, 9, 4));
      idle(10);

      // Ten hits with no consumer: eight queue, two drop, then drain in order.
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) tick(1'b1, AW'(32'h100 + i), mk(3, 7, 4, 9));
      idle(8);
      chk("ovf_level", 64'(fifo_level), 64'd8);
      chk("ovf_drop",  64'(drop_cnt),   64'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_addr", 64'(out_addr), 64'(32'h100 + i));
         idle(1);
      end
      chk("drain_empty", 64'(out_valid), 64'd0);

      // Full queue with a pop and a push in the same cycle: nothing dropped.
      out_ready = 1'b0;
      for (int i = 0; i < 21; i++) begin
         out_ready = (i == 14);
         tick(i < 9, AW'(32'h200 + i), mk(8, 3, 6, 5));
      end
      chk("fullpop_level", 64'(fifo_level), 64'd8);
      chk("fullpop_drop",  64'(drop_cnt),   64'd2);
      chk("fullpop_head",  64'(out_addr),   64'h201);
      out_ready = 1'b1;
      idle(10);

      // Epoch clear discards queued and in-flight reports.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b1, AW'(32'h300 + i), mk(3, 3, 3, 3));
      idle(6);
      tick(1'b1, 22'h0310, mk(4, 3, 5, 6));
      tick(1'b1, 22'h0311, mk(6, 5, 4, 3));
      idle(1);
      chk("preclr_level", 64'(fifo_level), 64'd3);
      query_rst_n = 1'b0;
      idle(1);
      query_rst_n = 1'b1;
      idle(1);
      chk("clr_out_valid", 64'(out_valid),  64'd0);
      chk("clr_level",     64'(fifo_level), 64'd0);
      chk("clr_drop",      64'(drop_cnt),   64'd0);
      out_ready = 1'b1;
      idle(10);

      // Threshold zero disables reporting entirely.
      threshold = 32'd0;
      for (int m = 0; m < 6; m++) tick(1'b1, AW'(32'h400 + m), mk(m, m + 1, m + 2, m + 3));
      idle(10);
      chk("thr0_level", 64'(fifo_level), 64'd0);
      chk("thr0_drop",  64'(drop_cnt),   64'd0);
      threshold = 32'd3;
      idle(2);

      // Random traffic with sparse consumer and occasional epoch clears.
      for (int i = 0; i < 500; i++) begin
         rows_t r;
         for (int j = 0; j < NH; j++) r[j] = CW'($urandom_range(2, 5));
         out_ready   = ($urandom_range(0, 99) < 30);
         query_rst_n = ($urandom_range(0, 149) != 0);
         tick(1'($urandom_range(0, 1)), AW'($urandom), r);
      end
      query_rst_n = 1'b1;
      out_ready   = 1'b1;
      idle(20);

      // Reset with traffic in flight returns every output to zero.
      out_ready = 1'b0;
      tick(1'b1, 22'h0555, mk(3, 4, 5, 6));
      idle(6);
      rst_n = 1'b0;
      idle(2);
      chk("rst_out_valid",  64'(out_valid),  64'd0);
      chk("rst_out_addr",   64'(out_addr),   64'd0);
      chk("rst_out_cnt",    64'(out_cnt),    64'd0);
      chk("rst_drop",       64'(drop_cnt),   64'd0);
      chk("rst_fifo_level", 64'(fifo_level), 64'd0);
      rst_n = 1'b1;
      idle(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
